// File: rtl/data_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - size_t  : access size encodings (byte / halfword / word / illegal)
//   - state_t : arbiter FSM state encodings (IDLE, ACCESS, RESP)
//   - MEM_BYTES_DEF : default data RAM size in bytes
//   - is_misaligned() : natural-alignment test used when the optional
//     alignment check (DATA_MEM_ARB_ALIGN_CHECK_EN) is compiled in
// ----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

    localparam int MEM_BYTES_DEF = 256;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles the two requester ports, the shared read-data return and the RAM
// command/return bus of the data-memory arbiter.
//
// Handshake: a requester raises pN_req with its command (rw/size/addr/wdata)
// stable and holds it until it sees pN_gnt. pN_gnt is combinational; the
// command is accepted on the rising clock edge where pN_req && pN_gnt are
// both high. Dropping pN_req before that edge withdraws the request with no
// side effect. Completion is a one-cycle pN_done pulse, with pN_err and the
// shared rdata valid in that same cycle (rdata then holds until the next done).
//
// Modports:
//   slave  : the arbiter (consumes requests and mem_rdata, drives the rest)
//   master : the requesters plus the RAM model (the opposite directions)
// ----------------------------------------------------------------------------
interface data_mem_arbiter_if;
    import data_mem_arbiter_pkg::*;

    // Port 0: pipeline MEM stage
    logic        p0_req;
    logic        p0_rw;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_done;
    logic        p0_err;

    // Port 1: loader / debug
    logic        p1_req;
    logic        p1_rw;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_done;
    logic        p1_err;

    // Shared read data
    logic [31:0] rdata;

    // RAM command / return
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_req, p0_rw, p0_size, p0_addr, p0_wdata,
        input  p1_req, p1_rw, p1_size, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_done, p0_err,
        output p1_gnt, p1_done, p1_err,
        output rdata,
        output mem_en, mem_rw, mem_addr, mem_size, mem_wdata
    );

    modport master (
        output p0_req, p0_rw, p0_size, p0_addr, p0_wdata,
        output p1_req, p1_rw, p1_size, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_done, p0_err,
        input  p1_gnt, p1_done, p1_err,
        input  rdata,
        input  mem_en, mem_rw, mem_addr, mem_size, mem_wdata
    );

endinterface

// File: rtl/data_mem_rr_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_rr_arbiter
// Two-request round-robin picker with a last-grant register.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   i_req0/1   : request from port 0 / port 1
//   i_take     : the pick is being consumed this cycle (updates last-grant)
//   o_valid    : at least one request present
//   o_port     : winning port (0 or 1)
// Last-grant resets to port 1 so port 0 wins the first tie.
// ----------------------------------------------------------------------------
module data_mem_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_valid,
    output logic o_port
);

    logic r_last;
    logic w_port;

    // On a tie the port that was not granted last wins; otherwise the lone
    // requester wins (port 0 when nobody is requesting, unused then).
    always_comb begin
        if (i_req0 && i_req1) begin
            w_port = ~r_last;
        end else begin
            w_port = i_req1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_take && (i_req0 || i_req1)) begin
            r_last <= w_port;
        end
    end

    assign o_valid = i_req0 || i_req1;
    assign o_port  = w_port;

endmodule

// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
// Arbitrates two requesters (port 0 = pipeline MEM stage, port 1 =
// loader/debug) onto a single-cycle data RAM. One access every three cycles:
//   IDLE   : grant the round-robin winner (pN_gnt), capture its command
//   ACCESS : mem_en high for one cycle with the captured command
//   RESP   : pN_done (and pN_err) pulse for the granted port
// Rejected accesses (size 11, address >= MEM_BYTES, or misaligned when the
// alignment check is compiled in) keep mem_en low and leave rdata unchanged.
// Reads capture mem_rdata into rdata; writes leave rdata untouched.
//
// Parameters:
//   MEM_BYTES : data RAM size in bytes
//   TIMEOUT   : reserved, must be 0 (RAM has no wait states)
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : data_mem_arbiter_if.slave (requesters + RAM bus)
//   o_dbg_state : current FSM state, for observation only
// Configuration macro:
//   DATA_MEM_ARB_ALIGN_CHECK_EN : when defined, misaligned halfword/word
//   accesses are rejected; when undefined they are issued to RAM unchanged.
// ----------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int TIMEOUT   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    data_mem_arbiter_if.slave        bus,
    output state_t                   o_dbg_state
);

    generate
        if (TIMEOUT != 0) begin : g_timeout_check
            $error("data_mem_arbiter: TIMEOUT must be 0");
        end
    endgenerate

    state_t      r_state;
    logic        r_port;
    logic        r_reject;
    logic        r_done0;
    logic        r_done1;
    logic        r_err0;
    logic        r_err1;
    logic [31:0] r_rdata;
    logic        r_mem_en;
    logic        r_mem_rw;
    logic [31:0] r_mem_addr;
    logic [1:0]  r_mem_size;
    logic [31:0] r_mem_wdata;

    logic        w_valid;
    logic        w_port;
    logic        w_take;
    logic        w_grant;
    logic        w_sel_rw;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_reject;

    // The pick is only consumed while idle; reset masks it so that no
    // grant escapes while the block is held in reset.
    assign w_take  = (r_state == ST_IDLE) && !reset;
    assign w_grant = w_take && w_valid;

    data_mem_rr_arbiter u_rr (
        .clk     (clk),
        .reset   (reset),
        .i_req0  (bus.p0_req),
        .i_req1  (bus.p1_req),
        .i_take  (w_take),
        .o_valid (w_valid),
        .o_port  (w_port)
    );

    // Command of the winning port
    assign w_sel_rw    = w_port ? bus.p1_rw    : bus.p0_rw;
    assign w_sel_size  = w_port ? bus.p1_size  : bus.p0_size;
    assign w_sel_addr  = w_port ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = w_port ? bus.p1_wdata : bus.p0_wdata;

    always_comb begin
        w_reject = (w_sel_size == SIZE_ILL) || (w_sel_addr >= 32'(MEM_BYTES));
`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
        w_reject = w_reject || is_misaligned(w_sel_size, w_sel_addr[1:0]);
`endif
    end

    // The RAM command registers are loaded on the grant edge so they are
    // live exactly during ACCESS; they read as zero in every other cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_port      <= 1'b0;
            r_reject    <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rdata     <= 32'h0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_size  <= 2'b00;
            r_mem_wdata <= 32'h0;
        end else begin
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_size  <= 2'b00;
            r_mem_wdata <= 32'h0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_port   <= w_port;
                        r_reject <= w_reject;
                        if (!w_reject) begin
                            r_mem_en    <= 1'b1;
                            r_mem_rw    <= w_sel_rw;
                            r_mem_addr  <= w_sel_addr;
                            r_mem_size  <= w_sel_size;
                            r_mem_wdata <= w_sel_wdata;
                        end
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_mem_en && !r_mem_rw) begin
                        r_rdata <= bus.mem_rdata;
                    end
                    if (r_port) begin
                        r_done1 <= 1'b1;
                        r_err1  <= r_reject;
                    end else begin
                        r_done0 <= 1'b1;
                        r_err0  <= r_reject;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_gnt    = w_grant && !w_port;
    assign bus.p1_gnt    = w_grant && w_port;
    assign bus.p0_done   = r_done0;
    assign bus.p1_done   = r_done1;
    assign bus.p0_err    = r_err0;
    assign bus.p1_err    = r_err1;
    assign bus.rdata     = r_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_size  = r_mem_size;
    assign bus.mem_wdata = r_mem_wdata;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   load_ram = 1'b0;
    state_t dbg_state;

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(.MEM_BYTES(256), .TIMEOUT(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] exp_q[$];
    bit          align_en;

    // Reference memory (model) and environment RAM (responds to the DUT)
    logic [7:0]  ref_mem [0:255];
    logic [7:0]  ram     [0:255];

    // ---------------- RAM environment ----------------
    always_comb begin
        bus.mem_rdata = 32'hDEAD_BEEF;
        if (bus.mem_en) begin
            case (bus.mem_size)
                2'b00:   bus.mem_rdata = {24'h0, ram[bus.mem_addr[7:0]]};
                2'b01:   bus.mem_rdata = {16'h0, ram[bus.mem_addr[7:0] + 8'd1],
                                          ram[bus.mem_addr[7:0]]};
                default: bus.mem_rdata = {ram[bus.mem_addr[7:0] + 8'd3],
                                          ram[bus.mem_addr[7:0] + 8'd2],
                                          ram[bus.mem_addr[7:0] + 8'd1],
                                          ram[bus.mem_addr[7:0]]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
        end else if (bus.mem_en && bus.mem_rw) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata[7:0];
            if (bus.mem_size != 2'b00)
                ram[bus.mem_addr[7:0] + 8'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_size == 2'b10) begin
                ram[bus.mem_addr[7:0] + 8'd2] <= bus.mem_wdata[23:16];
                ram[bus.mem_addr[7:0] + 8'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit misaligned_ref(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'b01 && (addr % 2) != 0) || (size == 2'b10 && (addr % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < size_bytes(size); i++)
            v = v | (32'(ref_mem[(addr + i) % 256]) << (8 * i));
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        for (int i = 0; i < size_bytes(size); i++)
            ref_mem[(addr + i) % 256] = 8'(wdata >> (8 * i));
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus.p0_req = 1'b0; bus.p0_rw = 1'b0; bus.p0_size = 2'b00; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0;
        bus.p1_req = 1'b0; bus.p1_rw = 1'b0; bus.p1_size = 2'b00; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0;
    endtask

    task automatic drive(input bit port, input logic req, input logic rw, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.p1_req = req; bus.p1_rw = rw; bus.p1_size = size; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_rw = rw; bus.p0_size = size; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        load_ram = 1'b1;
        @(negedge clk);
        load_ram = 1'b0;
        reset = 1'b0;
        exp_rdata = 32'h0;
        exp_q.delete();
    endtask

    // One complete access from an idle arbiter, checked cycle by cycle.
    task automatic do_access(input bit port, input logic rw, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bit          rej;
        int          n;
        logic [31:0] exp_v;
        logic        exp_en;
        rej = (size == 2'b11) || (addr >= 32'd256) || (align_en && misaligned_ref(size, addr));
        exp_en = !rej;
        @(negedge clk);
        drive(port, 1'b1, rw, size, addr, wdata);
        #1;
        n = 0;
        while (((port ? bus.p1_gnt : bus.p0_gnt) !== 1'b1) && n < 8) begin
            @(negedge clk); #1; n++;
        end
        n_vec++;
        if (n != 0) begin
            n_err++;
            $display("FAIL gnt_latency p%0d: got %0d cycles, expected 0", port, n);
            drive(port, 1'b0, rw, size, addr, wdata);
            return;
        end
        n_vec++;
        if ((port ? bus.p0_gnt : bus.p1_gnt) !== 1'b0) begin
            n_err++;
            $display("FAIL gnt_other p%0d: other gnt got 1, expected 0", port);
        end
        if (!rej && !rw) exp_rdata = ref_read(addr, size);
        if (!rej && rw) ref_write(addr, size, wdata);
        exp_q.push_back(exp_rdata);

        @(negedge clk);
        drive(port, 1'b0, rw, size, addr, wdata);
        #1;
        n_vec++;
        if (bus.mem_en !== exp_en) begin
            n_err++;
            $display("FAIL mem_en addr=%h size=%0d: got %b, expected %b", addr, size, bus.mem_en, exp_en);
        end
        if (!rej) begin
            n_vec++;
            if ({bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata} !== {rw, size, addr, wdata}) begin
                n_err++;
                $display("FAIL mem_cmd: got rw=%b size=%0d addr=%h wdata=%h, expected rw=%b size=%0d addr=%h wdata=%h",
                         bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata, rw, size, addr, wdata);
            end
        end
        n_vec++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL busy_quiet: gnt/done got %b%b%b%b, expected 0000",
                     bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done);
        end

        @(negedge clk); #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if ({bus.p0_done, bus.p1_done} !== (port ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL done p%0d: got p0_done=%b p1_done=%b", port, bus.p0_done, bus.p1_done);
        end
        n_vec++;
        if ({bus.p0_err, bus.p1_err} !== (rej ? (port ? 2'b01 : 2'b10) : 2'b00)) begin
            n_err++;
            $display("FAIL err p%0d addr=%h size=%0d: got p0_err=%b p1_err=%b, expected reject=%b",
                     port, addr, size, bus.p0_err, bus.p1_err, rej);
        end
        n_vec++;
        if (bus.rdata !== exp_v) begin
            n_err++;
            $display("FAIL rdata addr=%h size=%0d rw=%b: got %h, expected %h", addr, size, rw, bus.rdata, exp_v);
        end

        @(negedge clk); #1;
        n_vec++;
        if ({bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err, bus.mem_en} !== 5'b0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL after_done: got done=%b%b err=%b%b mem_en=%b state=%0d, expected zeros and IDLE",
                     bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err, bus.mem_en, dbg_state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        bus.p0_req = 1'b1;
        reset = 1'b1;
        load_ram = 1'b1;
        @(negedge clk); #1;
        n_vec++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_handshake: got gnt=%b%b done=%b%b err=%b%b, expected all 0",
                     bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err);
        end
        n_vec++;
        if ({bus.mem_en, bus.mem_rw, bus.mem_size} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_mem_ctl: got en=%b rw=%b size=%0d, expected 0", bus.mem_en, bus.mem_rw, bus.mem_size);
        end
        n_vec++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h, expected 0", bus.mem_addr, bus.mem_wdata);
        end
        n_vec++;
        if (bus.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h, expected 00000000", bus.rdata);
        end
        n_vec++;
        if (dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d, expected IDLE", dbg_state);
        end
        bus.p0_req = 1'b0;
        load_ram = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 32'h0;
    endtask

    task automatic test_read_word();
        do_access(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        n_vec++;
        if (bus.rdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL read_word0: got %h, expected 12345678", bus.rdata);
        end
    endtask

    task automatic test_tie();
        int cyc;
        int k;
        apply_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
        cyc = 0;
        k = 0;
        while (k < 6 && cyc < 30) begin
            #1;
            if (bus.p0_gnt === 1'b1 || bus.p1_gnt === 1'b1) begin
                n_vec++;
                if ({bus.p0_gnt, bus.p1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL tie_order grant %0d: got gnt=%b%b, expected p%0d", k,
                             bus.p0_gnt, bus.p1_gnt, k % 2);
                end
                n_vec++;
                if (cyc != 3 * k) begin
                    n_err++;
                    $display("FAIL tie_spacing grant %0d: got cycle %0d, expected %0d", k, cyc, 3 * k);
                end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (k != 6) begin
            n_err++;
            $display("FAIL tie_timeout: got %0d grants, expected 6", k);
        end
        idle_inputs();
        exp_rdata = ref_read(32'h4, 2'b10);
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (bus.rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL tie_rdata: got %h, expected %h", bus.rdata, exp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read_half();
        do_access(1'b1, 1'b1, 2'b01, 32'h2, 32'h0000_BBBB);
        do_access(1'b0, 1'b0, 2'b01, 32'h2, 32'h0);
        n_vec++;
        if (bus.rdata !== 32'h0000_BBBB) begin
            n_err++;
            $display("FAIL half_readback: got %h, expected 0000BBBB", bus.rdata);
        end
        do_access(1'b1, 1'b1, 2'b00, 32'h9, 32'hFFFF_FF5A);
        do_access(1'b0, 1'b0, 2'b00, 32'h9, 32'h0);
    endtask

    task automatic test_reject();
        do_access(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
        do_access(1'b1, 1'b1, 2'b10, 32'hFFFF_FFFC, 32'h1111_2222);
        do_access(1'b0, 1'b0, 2'b11, 32'h10, 32'h0);
        do_access(1'b0, 1'b0, 2'b00, 32'hFF, 32'h0);
    endtask

    task automatic test_misaligned();
        do_access(1'b0, 1'b0, 2'b10, 32'h6, 32'h0);
        do_access(1'b1, 1'b0, 2'b01, 32'h3, 32'h0);
        do_access(1'b0, 1'b1, 2'b10, 32'h21, 32'hCAFE_F00D);
        do_access(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h8, 32'h0);
        #1;
        n = 0;
        while (bus.p0_gnt !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        idle_inputs();
        #1;
        n_vec++;
        if (bus.mem_en !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_access: mem_en got %b, expected 1", bus.mem_en);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.mem_en, bus.mem_rw, bus.mem_size, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err} !== 8'b0 ||
            {bus.mem_addr, bus.rdata} !== 64'h0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL midreset_clear: got mem_en=%b addr=%h rdata=%h done=%b%b state=%0d, expected zeros and IDLE",
                     bus.mem_en, bus.mem_addr, bus.rdata, bus.p0_done, bus.p1_done, dbg_state);
        end
        @(negedge clk); #1;
        n_vec++;
        if ({bus.p0_done, bus.p1_done, bus.mem_en} !== 3'b0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL midreset_nodone: got done=%b%b mem_en=%b state=%0d, expected 0 and IDLE",
                     bus.p0_done, bus.p1_done, bus.mem_en, dbg_state);
        end
        reset = 1'b0;
        exp_rdata = 32'h0;
        exp_q.delete();
    endtask

    task automatic test_random();
        bit          port;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        int          r;
        for (int it = 0; it < 40; it++) begin
            port = 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'd256 + 32'($urandom_range(0, 1000));
            else if (r < 5)  addr = 32'($urandom_range(0, 63)) * 4;
            else             addr = 32'($urandom_range(0, 255));
            do_access(port, rw, size, addr, $urandom);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
        align_en = 1'b1;
`else
        align_en = 1'b0;
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[0] = 8'h78; ref_mem[1] = 8'h56; ref_mem[2] = 8'h34; ref_mem[3] = 8'h12;

        test_reset();
        test_read_word();
        test_tie();
        test_write_read_half();
        test_reject();
        test_misaligned();
        test_reset_mid();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, 256, data RAM size in bytes; addresses >= MEM_BYTES are out of range.
REQ-002 Parameter: TIMEOUT, 0, reserved; SHALL be 0 (single-cycle RAM, no wait states).
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 p0_req / p1_req  input  1 each  access request, port 0 = pipeline MEM stage, port 1 = loader/debug.
REQ-006 pN_rw  input  1  0 = read, 1 = write.
REQ-007 pN_size  input  2  00 byte, 01 halfword, 10 word; 11 illegal.
REQ-008 pN_addr  input  32  byte address.
REQ-009 pN_wdata  input  32  write data, right-justified.
REQ-010 pN_gnt  output  1  one-cycle pulse: request accepted, inputs captured.
REQ-011 pN_done  output  1  one-cycle pulse: access complete, rdata/err valid.
REQ-012 pN_err  output  1  valid with pN_done: access rejected.
REQ-013 rdata  output  32  read data, shared by both ports, held until next done.
REQ-014 mem_en, mem_rw  output  1 each  RAM enable and read/write.
REQ-015 mem_addr  output  32; mem_size  output  2; mem_wdata  output  32  RAM command.
REQ-016 mem_rdata  input  32  RAM read data, valid in the cycle mem_en is high.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-018 IDLE: if any req, grant winner, capture rw/size/addr/wdata, pulse pN_gnt, go ACCESS; else stay.
REQ-019 Arbitration round-robin: both requesting -> port other than last granted wins; last-granted resets to port 1 (port 0 wins first tie).
REQ-020 ACCESS: mem_en=1 for exactly one cycle with captured command; read captures mem_rdata into rdata; go RESP.
REQ-021 RESP: pulse pN_done for granted port; go IDLE; next grant no earlier than following cycle.
REQ-022 Latency: req seen at edge T -> gnt in cycle T, mem_en in T+1, done in T+2; throughput one access per 3 cycles.
REQ-023 Requester holds req until gnt; req deasserted before gnt is dropped without side effect.
REQ-024 Rejected access (size 11, out of range, or misaligned when checking enabled): ACCESS keeps mem_en=0, rdata unchanged, done with err=1.
REQ-025 Reads: byte/halfword results zero-extended to 32 bits as returned by RAM; writes leave rdata unchanged.
REQ-026 mem_en, pN_gnt, pN_done, pN_err zero whenever not explicitly asserted.

Reset
REQ-027 Reset asserted in any state -> IDLE immediately; in-flight access abandoned, no done pulse.
REQ-028 Reset values: all outputs 0, rdata 0, last-granted = port 1.

Configuration
REQ-029 DATA_MEM_ARB_ALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 rejected per REQ-024.
REQ-030 Macro undefined: no alignment check; misaligned accesses issued to RAM unchanged.

Structure
REQ-031 Shared package holds size encodings (BYTE=00, HALF=01, WORD=10), FSM state encodings, MEM_BYTES default.
REQ-032 One sub-module natural: data_mem_rr_arbiter (two-request round-robin picker with last-grant register).

Verification
REQ-033 p0 read word addr 0, RAM word 0 = 0x12345678 -> gnt at T, mem_en T+1, p0_done T+2, rdata 0x12345678, err 0.
REQ-034 p0 and p1 req same cycle after reset -> p0 granted first, p1 granted 3 cycles later; repeated -> alternates.
REQ-035 p1 write half 0xBBBB addr 2, then p0 read half addr 2 -> rdata 0x0000BBBB.
REQ-036 p0 read word addr 0x100 -> no mem_en, p0_done with err=1, rdata unchanged.
REQ-037 With macro: word read addr 6 -> err=1, no mem_en; without: mem_en issued, err=0.
REQ-038 Reset asserted during ACCESS -> no done pulse, FSM IDLE, all outputs 0 next cycle.
